// File: rtl/instr_loader_pkg.sv
// Shared types for the instruction loader: FSM state encoding and byte-lane index.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        CSUM  = 3'd4
    } state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in the MSBs.
module byte_packer
    import instr_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         accept,
    input  logic [7:0]   in_data,
    output logic [W-1:0] word_next,
    output logic         word_full
);

    logic [W-1:0] word_q;
    lane_t        lane_q;

    // word_next already holds the byte being accepted, so the caller can
    // consume a completed word in the same cycle as its last byte.
    assign word_next = {word_q[W-9:0], in_data};
    assign word_full = accept && (lane_q == lane_t'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (clear) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (accept) begin
            word_q <= word_next;
            lane_q <= lane_q + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams big-endian bytes into 32-bit instruction-memory word writes.
// Optional trailing checksum word enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [COUNT_WIDTH-1:0] total_q, written_q, written_inc;
    logic                   start_acc, accept, word_full;
    logic [INSTR_WIDTH-1:0] word_next;

    assign start_acc   = start && (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign written_inc = written_q + COUNT_WIDTH'(1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == RECV) || (state_q == CSUM);
`else
    assign in_ready = (state_q == RECV);
`endif
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    byte_packer #(.W(INSTR_WIDTH)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_acc),
        .accept    (accept),
        .in_data   (in_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = (word_count == '0) ? DONE : RECV;
            RECV:  if (word_full) state_d = WRITE;
            WRITE: begin
                if (written_inc == total_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM:  if (word_full) state_d = DONE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            total_q   <= '0;
            written_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                addr_q    <= base_addr & ~ADDR_WIDTH'(3);
                total_q   <= word_count;
                written_q <= '0;
            end else if (state_q == WRITE) begin
                addr_q    <= addr_q + ADDR_WIDTH'(4);
                written_q <= written_inc;
            end
        end
    end

    // Write port is registered and loaded on the last byte, so the strobe
    // lands exactly in the WRITE cycle; addr/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if ((state_q == RECV) && word_full) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= word_next;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] sum_q;
    logic                   err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (start_acc) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (word_full) begin
            if (state_q == RECV) sum_q <= sum_q + word_next;
            else                 err_q <= (word_next != sum_q);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a queue-based reference model.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, busy, done, err;
    logic [31:0] wr_addr, wr_data;

    instr_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          wr_c_q[$];
    logic [7:0]  bytes_q[$];
    bit          rdy_seen;

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wr_a_q.push_back(wr_addr);
            wr_d_q.push_back(wr_data);
            wr_c_q.push_back(cyc);
        end
        if (rst_n && in_ready) rdy_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_a_q.delete();
        wr_d_q.delete();
        wr_c_q.delete();
        rdy_seen = 1'b0;
    endtask

    task automatic rand_bytes(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    // Offer one byte with random stalls; returns the edge number that took it.
    task automatic feed_byte(input logic [7:0] b, input int stall, output int acc);
        bit ok;
        acc = -1;
        for (int n = 0; n < 300; n++) begin
            in_data  = b;
            in_valid = ($urandom_range(99) >= stall);
            ok = in_valid && in_ready;
            step();
            if (ok) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("feed_timeout", 1, 0);
            acc = cyc;
        end
    endtask

    task automatic run_load(input logic [31:0] base, input int cnt, input int stall, input bit bad);
        logic [31:0] ea_q[$];
        logic [31:0] ed_q[$];
        int          acc_q[$];
        logic [31:0] a, w, sum;
        int          acc, last, dcyc, lat;
        bit          got_done;
        logic        exp_err;

        a = base & ~32'h3;
        sum = '0;
        for (int i = 0; i < cnt; i++) begin
            w = {bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]};
            ea_q.push_back(a);
            ed_q.push_back(w);
            sum += w;
            a += 32'd4;
        end
        clear_mon();

        start = 1'b1; base_addr = base; word_count = 16'(cnt);
        in_valid = 1'b1; in_data = 8'hAA;
        chk("rdy_at_start", in_ready, 0);
        step();
        start = 1'b0; in_valid = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_clr_on_start", err, 0);

        last = cyc;
        for (int i = 0; i < 4 * cnt; i++) begin
            feed_byte(bytes_q[i], stall, acc);
            if (i % 4 == 3) acc_q.push_back(acc);
            last = acc;
        end
        in_valid = 1'b0;

`ifdef INSTR_LOADER_CHECKSUM_EN
        w = sum + (bad ? 32'd1 : 32'd0);
        exp_err = bad;
        for (int k = 0; k < 4; k++) begin
            feed_byte(w[31-8*k -: 8], stall, acc);
            last = acc;
        end
        in_valid = 1'b0;
        lat = 0;
`else
        exp_err = 1'b0;
        lat = 1;
`endif

        got_done = 1'b0;
        dcyc = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                got_done = 1'b1;
                dcyc = cyc;
                break;
            end
            step();
        end
        chk("done_seen", got_done, 1);
        if (got_done) begin
            chk("done_cycle", dcyc, last + lat);
            chk("busy_at_done", busy, 1);
            chk("err_at_done", err, exp_err);
            step();
            chk("busy_after_done", busy, 0);
            chk("done_one_pulse", done, 0);
            chk("err_held", err, exp_err);
        end

        chk("wr_count", wr_a_q.size(), ea_q.size());
        for (int i = 0; i < wr_a_q.size() && i < ea_q.size(); i++) begin
            chk("wr_addr", wr_a_q[i], ea_q[i]);
            chk("wr_data", wr_d_q[i], ed_q[i]);
            chk("wr_cycle", wr_c_q[i], acc_q[i]);
        end
    endtask

    task automatic zero_load();
        clear_mon();
        start = 1'b1; word_count = '0; base_addr = $urandom;
        in_valid = 1'b1; in_data = 8'h55;
        chk("z_rdy_at_start", in_ready, 0);
        step();
        start = 1'b0;
        chk("z_busy", busy, 1);
        chk("z_done", done, 1);
        chk("z_err_clear", err, 0);
        step();
        chk("z_busy_after", busy, 0);
        chk("z_done_after", done, 0);
        step();
        step();
        in_valid = 1'b0;
        chk("z_no_write", wr_a_q.size(), 0);
        chk("z_rdy_never", rdy_seen, 0);
    endtask

    initial begin
        int acc;

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();

        bytes_q = {8'h20, 8'h08, 8'h00, 8'h05};
        run_load(32'h0000_0010, 1, 0, 1'b0);

        rand_bytes(12);
        run_load(32'h0000_0003, 3, 50, 1'b0);

        zero_load();

        rand_bytes(8);
        run_load(32'hFFFF_FFFC, 2, 20, 1'b0);

        // reset with a half-assembled word in flight
        clear_mon();
        start = 1'b1; base_addr = 32'h40; word_count = 16'd1;
        step();
        start = 1'b0;
        feed_byte(8'hDE, 0, acc);
        feed_byte(8'hAD, 0, acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mid_rst_no_write", wr_a_q.size(), 0);
        bytes_q = {8'h12, 8'h34, 8'h56, 8'h78};
        run_load(32'h40, 1, 10, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        bytes_q = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        run_load(32'h100, 2, 0, 1'b0);
        run_load(32'h100, 2, 0, 1'b1);
        for (int k = 0; k < 5; k++) step();
        chk("err_sticky", err, 1);
        zero_load();
`endif

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(5, 1);
            rand_bytes(4 * n);
            run_load($urandom, n, $urandom_range(60), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
